// File: rtl/basis_meas_sequencer_pkg.sv
// Shared types and defaults for the basis measurement sequencer slice.
// Holds the FSM encoding, basis drive codes and calibration defaults.
package basis_meas_sequencer_pkg;
  localparam int CAL_SETTLE_CYCLES = 16;
  localparam int CAL_AVG_SAMPLES   = 8;
  localparam int ADC_WIDTH         = 12;
  localparam int DATA_WIDTH        = 16;

  localparam logic [15:0] Q1_15_ONE  = 16'h7FFF;
  localparam logic [15:0] BASIS_ONE  = Q1_15_ONE;
  localparam logic [15:0] BASIS_ZERO = 16'h0000;

  localparam int MEAS_AVG_SHIFT = $clog2(CAL_AVG_SAMPLES);

  typedef enum logic [2:0] {
    MEAS_IDLE,
    MEAS_APPLY,
    MEAS_SETTLE,
    MEAS_SAMPLE,
    MEAS_DONE
  } meas_state_t;
endpackage

// File: rtl/basis_meas_sequencer_if.sv
// Control, plant drive/ADC and result bundle between the calibration FSMs,
// the sequencer and the plant front-end.
interface basis_meas_sequencer_if
  import basis_meas_sequencer_pkg::*;
#(
  parameter int ADC_W  = ADC_WIDTH,
  parameter int DATA_W = DATA_WIDTH
);
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] x0_drive;
  logic [DATA_W-1:0] x1_drive;
  logic              adc_valid;
  logic [ADC_W-1:0]  adc_ch0;
  logic [ADC_W-1:0]  adc_ch1;
  logic [ADC_W-1:0]  m_c0_o0;
  logic [ADC_W-1:0]  m_c0_o1;
  logic [ADC_W-1:0]  m_c1_o0;
  logic [ADC_W-1:0]  m_c1_o1;
  logic              sat_flag;

  modport slave (
    input  start, abort, adc_valid, adc_ch0, adc_ch1,
    output busy, done, x0_drive, x1_drive,
           m_c0_o0, m_c0_o1, m_c1_o0, m_c1_o1, sat_flag
  );

  modport master (
    output start, abort, adc_valid, adc_ch0, adc_ch1,
    input  busy, done, x0_drive, x1_drive,
           m_c0_o0, m_c0_o1, m_c1_o0, m_c1_o1, sat_flag
  );
endinterface

// File: rtl/basis_meas_sequencer_accum.sv
// Per-channel signed accumulator; avg already includes the current sample so
// the final sample of a column can be folded in without an extra cycle.
module meas_channel_accum #(
  parameter int ADC_W = 12,
  parameter int SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    add,
  input  logic signed [ADC_W-1:0] sample,
  output logic signed [ADC_W-1:0] avg,
  output logic                    sat_hit
);
  localparam int ACC_W = ADC_W + SHIFT;
  localparam logic signed [ADC_W-1:0] S_MAX = {1'b0, {(ADC_W-1){1'b1}}};
  localparam logic signed [ADC_W-1:0] S_MIN = {1'b1, {(ADC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] sum;

  assign sum     = acc_q + ACC_W'(sample);
  assign avg     = ADC_W'(sum >>> SHIFT);
  assign sat_hit = add && ((sample == S_MAX) || (sample == S_MIN));

  // clear wins over add: the last sample of a column is consumed via avg
  always_ff @(posedge clk) begin
    if (rst || clear) acc_q <= '0;
    else if (add)     acc_q <= sum;
  end
endmodule

// File: rtl/basis_meas_sequencer.sv
// Drives the two unit basis vectors into the plant, settles, averages both ADC
// outputs per column and returns the 2x2 transfer matrix with a done pulse.
module basis_meas_sequencer
  import basis_meas_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = CAL_SETTLE_CYCLES,
  parameter int AVG_SAMPLES   = CAL_AVG_SAMPLES,
  parameter int ADC_W         = ADC_WIDTH,
  parameter int DATA_W        = DATA_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  basis_meas_sequencer_if.slave bus
);
  localparam int SW        = $clog2(SETTLE_CYCLES + 1);
  localparam int CW        = $clog2(AVG_SAMPLES + 1);
  localparam int AVG_SHIFT = $clog2(AVG_SAMPLES);
  localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]     SAMP_LAST   = CW'(AVG_SAMPLES - 1);
  localparam logic [DATA_W-1:0] ONE_D       = DATA_W'(BASIS_ONE);
  localparam logic [DATA_W-1:0] ZERO_D      = DATA_W'(BASIS_ZERO);

  meas_state_t   state_q, state_d;
  logic          col_q, col_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CW-1:0] samp_q, samp_d;
  logic          acc_clr, acc_add, cap0, cap1, start_acc, run;
  logic [ADC_W-1:0] avg0, avg1;
  logic          hit0, hit1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MEAS_IDLE;
      col_q    <= 1'b0;
      settle_q <= '0;
      samp_q   <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      settle_q <= settle_d;
      samp_q   <= samp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    settle_d  = settle_q;
    samp_d    = samp_q;
    acc_clr   = 1'b0;
    acc_add   = 1'b0;
    cap0      = 1'b0;
    cap1      = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      MEAS_IDLE: if (bus.start) begin
        state_d   = MEAS_APPLY;
        col_d     = 1'b0;
        acc_clr   = 1'b1;
        start_acc = 1'b1;
      end
      MEAS_APPLY: begin
        settle_d = '0;
        state_d  = MEAS_SETTLE;
      end
      MEAS_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          samp_d   = '0;
          state_d  = MEAS_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      MEAS_SAMPLE: if (bus.adc_valid) begin
        acc_add = 1'b1;
        if (samp_q == SAMP_LAST) begin
          acc_clr = 1'b1;
          samp_d  = '0;
          cap0    = !col_q;
          cap1    = col_q;
          col_d   = 1'b1;
          state_d = col_q ? MEAS_DONE : MEAS_APPLY;
        end else begin
          samp_d = samp_q + 1'b1;
        end
      end
      MEAS_DONE: state_d = MEAS_IDLE;
      default:   state_d = MEAS_IDLE;
    endcase
    // abort overrides everything, including a column's final sample
    if (bus.abort && (state_q != MEAS_IDLE)) begin
      state_d  = MEAS_IDLE;
      settle_d = '0;
      samp_d   = '0;
      acc_clr  = 1'b1;
      acc_add  = 1'b0;
      cap0     = 1'b0;
      cap1     = 1'b0;
    end
  end

  meas_channel_accum #(.ADC_W(ADC_W), .SHIFT(AVG_SHIFT)) u_acc [1:0] (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clr),
    .add    (acc_add),
    .sample ({bus.adc_ch1, bus.adc_ch0}),
    .avg    ({avg1, avg0}),
    .sat_hit({hit1, hit0})
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.m_c0_o0  <= '0;
      bus.m_c0_o1  <= '0;
      bus.m_c1_o0  <= '0;
      bus.m_c1_o1  <= '0;
      bus.sat_flag <= 1'b0;
    end else begin
      if (cap0) begin
        bus.m_c0_o0 <= avg0;
        bus.m_c0_o1 <= avg1;
      end
      if (cap1) begin
        bus.m_c1_o0 <= avg0;
        bus.m_c1_o1 <= avg1;
      end
      if (start_acc)          bus.sat_flag <= 1'b0;
      else if (hit0 || hit1)  bus.sat_flag <= 1'b1;
    end
  end

  assign run          = (state_q == MEAS_APPLY) || (state_q == MEAS_SETTLE) ||
                        (state_q == MEAS_SAMPLE);
  assign bus.x0_drive = (run && !col_q) ? ONE_D : ZERO_D;
  assign bus.x1_drive = (run &&  col_q) ? ONE_D : ZERO_D;
  assign bus.busy     = (state_q != MEAS_IDLE);
  assign bus.done     = (state_q == MEAS_DONE);
endmodule

// File: tb/tb_basis_meas_sequencer.sv
// Bench for basis_meas_sequencer: table of measurement scenarios, hand-built
// abort/reset/start corner sequences and randomized measurements vs a model.
module tb_basis_meas_sequencer;
  localparam int S = 16;
  localparam int A = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_m [4];

  always #5 clk = ~clk;

  basis_meas_sequencer_if #(.ADC_W(12), .DATA_W(16)) bus ();

  basis_meas_sequencer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int kind;   // 0 const, 1 ramp, 2 random, 3 const with 0x7FF first col1 ch0 sample
    int vper;   // 0 random gaps, else valid every vper-th cycle
    int k0;
    int k1;
    bit spam;   // hold start high for the whole measurement
    int e00, e01, e10, e11;
    bit esat;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int floor_div(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n != 0) && (s < 0)) q--;
    return q;
  endfunction

  function automatic bit is_sat(input int v);
    return (v == 2047) || (v == -2048);
  endfunction

  task automatic chk_results(input string tag);
    chk({tag, "_c0o0"}, int'($signed(bus.m_c0_o0)), exp_m[0]);
    chk({tag, "_c0o1"}, int'($signed(bus.m_c0_o1)), exp_m[1]);
    chk({tag, "_c1o0"}, int'($signed(bus.m_c1_o0)), exp_m[2]);
    chk({tag, "_c1o1"}, int'($signed(bus.m_c1_o1)), exp_m[3]);
  endtask

  task automatic chk_run(input int col, input bit sat_e);
    chk("busy",  int'(bus.busy), 1);
    chk("done",  int'(bus.done), 0);
    chk("x0",    int'(bus.x0_drive), (col == 0) ? 32'h7FFF : 0);
    chk("x1",    int'(bus.x1_drive), (col == 1) ? 32'h7FFF : 0);
    chk("sat",   int'(bus.sat_flag), int'(sat_e));
  endtask

  // ADC traffic outside SAMPLE must be ignored, including saturating codes
  task automatic junk();
    int r;
    r = int'($urandom_range(0, 4095));
    bus.adc_valid = 1'($urandom_range(0, 1));
    bus.adc_ch0   = ($urandom_range(0, 3) == 0) ? 12'h7FF : r[11:0];
    bus.adc_ch1   = ($urandom_range(0, 3) == 0) ? 12'h800 : r[11:0];
  endtask

  // One measurement: the model tracks which cycles are apply/settle/sample
  // from the documented timing and averages the samples it actually offered.
  task automatic run_meas(input int kind, input int vper, input int k0, input int k1,
                          input bit spam, input bit do_abort);
    int cyc, n, s0, s1, v0, v1, guard;
    bit v, sat_e;
    sat_e = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = spam;
    cyc = 1;
    chk("sat_clear", int'(bus.sat_flag), 0);
    for (int col = 0; col < 2; col++) begin
      for (int j = 0; j <= S; j++) begin
        chk_run(col, sat_e);
        junk();
        step();
        cyc++;
      end
      n = 0; s0 = 0; s1 = 0; guard = 0;
      while (n < A) begin
        chk_run(col, sat_e);
        v = (vper == 0) ? 1'($urandom_range(0, 1)) : (guard % vper == vper - 1);
        case (kind)
          0: begin v0 = k0; v1 = k1; end
          1: begin v0 = n + 8 * col; v1 = -1; end
          2: begin v0 = int'($urandom_range(0, 4095)) - 2048; v1 = int'($urandom_range(0, 4095)) - 2048; end
          default: begin v0 = (col == 1 && n == 0) ? 2047 : k0; v1 = k1; end
        endcase
        bus.adc_valid = v;
        bus.adc_ch0   = v0[11:0];
        bus.adc_ch1   = v1[11:0];
        if (do_abort && col == 1 && n == 3) begin
          bus.abort = 1'b1;
          step();
          bus.abort = 1'b0;
          bus.start = 1'b0;
          bus.adc_valid = 1'b0;
          chk("abort_busy", int'(bus.busy), 0);
          chk("abort_x0", int'(bus.x0_drive), 0);
          chk("abort_x1", int'(bus.x1_drive), 0);
          chk_results("abort");
          for (int k = 0; k < 4; k++) begin
            chk("abort_nodone", int'(bus.done), 0);
            step();
          end
          return;
        end
        if (v) begin
          n++;
          s0 += v0;
          s1 += v1;
          if (is_sat(v0) || is_sat(v1)) sat_e = 1'b1;
        end
        step();
        cyc++;
        guard++;
        if (guard > 500) begin
          chk("sample_timeout", guard, 0);
          bus.start = 1'b0;
          return;
        end
      end
      exp_m[2*col]   = floor_div(s0, A);
      exp_m[2*col+1] = floor_div(s1, A);
      if (col == 0) begin
        chk("c0_early_o0", int'($signed(bus.m_c0_o0)), exp_m[0]);
        chk("c0_early_o1", int'($signed(bus.m_c0_o1)), exp_m[1]);
      end
    end
    chk("done_pulse", int'(bus.done), 1);
    chk("done_busy",  int'(bus.busy), 1);
    chk("done_x0",    int'(bus.x0_drive), 0);
    chk("done_x1",    int'(bus.x1_drive), 0);
    chk("done_sat",   int'(bus.sat_flag), int'(sat_e));
    if (vper == 1) chk("latency", cyc, 2 * (1 + S + A) + 1);
    chk_results("done");
    bus.start = 1'b0;
    bus.adc_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_done", int'(bus.done), 0);
      chk("post_busy", int'(bus.busy), 0);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.adc_valid = 1'b0;
    bus.adc_ch0 = '0; bus.adc_ch1 = '0;
    for (int i = 0; i < 4; i++) exp_m[i] = 0;

    tbl[0] = '{0, 1,   100,  -50, 1'b0,   100,  -50,   100,  -50, 1'b0};
    tbl[1] = '{1, 1,     0,    0, 1'b0,     3,   -1,    11,   -1, 1'b0};
    tbl[2] = '{0, 3,   100,  -50, 1'b0,   100,  -50,   100,  -50, 1'b0};
    tbl[3] = '{3, 1,   100,  -50, 1'b1,   100,  -50,   343,  -50, 1'b1};
    tbl[4] = '{0, 1, -2048, 2047, 1'b0, -2048, 2047, -2048, 2047, 1'b1};
    tbl[5] = '{0, 1,    -1,   -7, 1'b0,    -1,   -7,    -1,   -7, 1'b0};
    tbl[6] = '{0, 0,     5,   -3, 1'b0,     5,   -3,     5,   -3, 1'b0};

    // reset state
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_x0",   int'(bus.x0_drive), 0);
    chk("rst_x1",   int'(bus.x1_drive), 0);
    chk("rst_sat",  int'(bus.sat_flag), 0);
    chk_results("rst");

    foreach (tbl[i]) begin
      run_meas(tbl[i].kind, tbl[i].vper, tbl[i].k0, tbl[i].k1, tbl[i].spam, 1'b0);
      chk("tbl_c0o0", int'($signed(bus.m_c0_o0)), tbl[i].e00);
      chk("tbl_c0o1", int'($signed(bus.m_c0_o1)), tbl[i].e01);
      chk("tbl_c1o0", int'($signed(bus.m_c1_o0)), tbl[i].e10);
      chk("tbl_c1o1", int'($signed(bus.m_c1_o1)), tbl[i].e11);
      chk("tbl_sat",  int'(bus.sat_flag), int'(tbl[i].esat));
    end

    // abort in column-1 SAMPLE: column 0 holds the new values, column 1 the old
    run_meas(0, 1, 200, 300, 1'b0, 1'b1);
    chk("abort_c0o0", int'($signed(bus.m_c0_o0)), 200);
    chk("abort_c1o0", int'($signed(bus.m_c1_o0)), 5);
    chk("abort_c1o1", int'($signed(bus.m_c1_o1)), -3);

    // start and abort together in IDLE: start wins, then abort in APPLY
    bus.start = 1'b1; bus.abort = 1'b1;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("sa_busy", int'(bus.busy), 1);
    chk("sa_x0",   int'(bus.x0_drive), 32'h7FFF);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("sa_abort_busy", int'(bus.busy), 0);
    chk("sa_abort_x0",   int'(bus.x0_drive), 0);

    // reset while in SETTLE
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("pre_rst_busy", int'(bus.busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_m[i] = 0;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_x0",   int'(bus.x0_drive), 0);
    chk("mid_rst_x1",   int'(bus.x1_drive), 0);
    chk("mid_rst_sat",  int'(bus.sat_flag), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk_results("mid_rst");
    run_meas(0, 1, 100, -50, 1'b0, 1'b0);
    chk("after_rst_c1o1", int'($signed(bus.m_c1_o1)), -50);

    // randomized measurements against the model
    for (int r = 0; r < 6; r++)
      run_meas(2, int'($urandom_range(0, 2)), 0, 0, 1'($urandom_range(0, 1)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
